// File: rtl/seg7_pkg.sv
// Segment patterns and bit ordering shared by the 7-segment scan driver and its decoder.
// Bit 0 is segment a through bit 6 segment g; a 1 lights the segment before polarity inversion.
package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam seg_t SEG_0     = 7'b0111111;
   localparam seg_t SEG_1     = 7'b0000110;
   localparam seg_t SEG_2     = 7'b1011011;
   localparam seg_t SEG_3     = 7'b1001111;
   localparam seg_t SEG_4     = 7'b1100110;
   localparam seg_t SEG_5     = 7'b1101101;
   localparam seg_t SEG_6     = 7'b1111101;
   localparam seg_t SEG_7     = 7'b0000111;
   localparam seg_t SEG_8     = 7'b1111111;
   localparam seg_t SEG_9     = 7'b1101111;
   localparam seg_t SEG_HEX_A = 7'b1110111;
   localparam seg_t SEG_HEX_B = 7'b1111100;
   localparam seg_t SEG_HEX_C = 7'b0111001;
   localparam seg_t SEG_HEX_D = 7'b1011110;
   localparam seg_t SEG_HEX_E = 7'b1111001;
   localparam seg_t SEG_HEX_F = 7'b1110001;
   localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder with a forced-blank input.
// Define SEG_HEX_EN to show codes 10-15 as A-F; otherwise those codes are dark.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:  seg = SEG_0;
         4'd1:  seg = SEG_1;
         4'd2:  seg = SEG_2;
         4'd3:  seg = SEG_3;
         4'd4:  seg = SEG_4;
         4'd5:  seg = SEG_5;
         4'd6:  seg = SEG_6;
         4'd7:  seg = SEG_7;
         4'd8:  seg = SEG_8;
         4'd9:  seg = SEG_9;
`ifdef SEG_HEX_EN
         4'd10: seg = SEG_HEX_A;
         4'd11: seg = SEG_HEX_B;
         4'd12: seg = SEG_HEX_C;
         4'd13: seg = SEG_HEX_D;
         4'd14: seg = SEG_HEX_E;
         4'd15: seg = SEG_HEX_F;
`else
         default: seg = SEG_BLANK;
`endif
      endcase
      if (blank) seg = SEG_BLANK;
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner: per-frame BCD snapshot, leading-zero blanking,
// dead time between digits. SEG_HEX_EN (see seg7_decode) enables A-F glyphs for codes 10-15.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NDIGITS    = 4,
   parameter int PRESCALE   = 1024,
   parameter int DEADTIME   = 2,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [4*NDIGITS-1:0]   din,
   input  logic [NDIGITS-1:0]     dp,
   input  logic                   blank_lz,
   output logic [6:0]             seg,
   output logic                   seg_dp,
   output logic [NDIGITS-1:0]     dig,
   output logic                   frame_start
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   logic [PW-1:0]        pre_q, pre_d;
   logic [SW-1:0]        slot_q, slot_d;
   logic [4*NDIGITS-1:0] din_sh_q, din_sh_d;
   logic [NDIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic                 blz_sh_q, blz_sh_d;
   logic [6:0]           seg_q, seg_d;
   logic                 seg_dp_q, seg_dp_d;
   logic [NDIGITS-1:0]   dig_q, dig_d;
   logic                 frame_start_q, frame_start_d;

   logic                 snap;
   logic [4*NDIGITS-1:0] din_eff;
   logic [NDIGITS-1:0]   dp_eff;
   logic                 blz_eff;
   logic [NDIGITS-1:0]   lz_mask;
   logic                 zero_run;
   int                   slot_idx;
   logic [3:0]           digit_code;
   logic [6:0]           seg_dec;

   // The snapshot cycle decodes straight from the inputs so slot 0 shows the new frame at once.
   always_comb begin
      snap       = en && (pre_q == '0) && (slot_q == '0);
      din_eff    = snap ? din : din_sh_q;
      dp_eff     = snap ? dp : dp_sh_q;
      blz_eff    = snap ? blank_lz : blz_sh_q;
      slot_idx   = int'(slot_q);
      digit_code = din_eff[4*slot_idx +: 4];
   end

   // A digit is blanked while it and every more significant digit are zero; digit 0 always shows.
   always_comb begin
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int i = NDIGITS - 1; i >= 1; i--) begin
         zero_run   = zero_run && (din_eff[4*i +: 4] == 4'd0);
         lz_mask[i] = blz_eff && zero_run;
      end
   end

   seg7_decode u_decode (
      .code  (digit_code),
      .blank (lz_mask[slot_idx]),
      .seg   (seg_dec)
   );

   always_comb begin
      pre_d         = pre_q;
      slot_d        = slot_q;
      din_sh_d      = din_sh_q;
      dp_sh_d       = dp_sh_q;
      blz_sh_d      = blz_sh_q;
      seg_d         = {7{ACTIVE_LOW}};
      seg_dp_d      = ACTIVE_LOW;
      dig_d         = {NDIGITS{ACTIVE_LOW}};
      frame_start_d = 1'b0;
      if (en) begin
         if (snap) begin
            din_sh_d = din;
            dp_sh_d  = dp;
            blz_sh_d = blank_lz;
         end
         if (int'(pre_q) == PRESCALE - 1) begin
            pre_d  = '0;
            slot_d = (slot_idx == NDIGITS - 1) ? '0 : slot_q + SW'(1);
         end else begin
            pre_d = pre_q + PW'(1);
         end
         seg_d         = seg_dec ^ {7{ACTIVE_LOW}};
         seg_dp_d      = dp_eff[slot_idx] ^ ACTIVE_LOW;
         dig_d         = ((int'(pre_q) >= DEADTIME) ? (NDIGITS'(1) << slot_q) : '0)
                         ^ {NDIGITS{ACTIVE_LOW}};
         frame_start_d = snap;
      end else begin
         pre_d  = '0;
         slot_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q         <= '0;
         slot_q        <= '0;
         din_sh_q      <= '0;
         dp_sh_q       <= '0;
         blz_sh_q      <= 1'b0;
         seg_q         <= {7{ACTIVE_LOW}};
         seg_dp_q      <= ACTIVE_LOW;
         dig_q         <= {NDIGITS{ACTIVE_LOW}};
         frame_start_q <= 1'b0;
      end else begin
         pre_q         <= pre_d;
         slot_q        <= slot_d;
         din_sh_q      <= din_sh_d;
         dp_sh_q       <= dp_sh_d;
         blz_sh_q      <= blz_sh_d;
         seg_q         <= seg_d;
         seg_dp_q      <= seg_dp_d;
         dig_q         <= dig_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg         = seg_q;
   assign seg_dp      = seg_dp_q;
   assign dig         = dig_q;
   assign frame_start = frame_start_q;

endmodule
